// File: rtl/rock_pkg.sv
// Shared types for the adaptive rocking controller: FSM states, search axes and candidate order.
// Pure declarations; no timing or flow control of its own.
package rock_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BASE,
        S_APPLY,
        S_SETTLE,
        S_TRIAL,
        S_DECIDE,
        S_PARKED
    } state_t;

    typedef enum logic { AXIS_A, AXIS_F } axis_t;
    typedef enum logic { DIR_UP, DIR_DN } dir_t;

    typedef struct packed {
        axis_t axis;
        dir_t  dir;
    } cand_t;

    localparam int    N_CAND     = 4;
    localparam cand_t CAND_FIRST = '{axis: AXIS_A, dir: DIR_UP};

    // A+ -> A- -> F+ -> F- -> A+
    function automatic cand_t next_cand(input cand_t c);
        cand_t n;
        n.axis = (c.dir == DIR_DN) ? axis_t'(~c.axis) : c.axis;
        n.dir  = dir_t'(~c.dir);
        return n;
    endfunction

endpackage

// File: rtl/stress_window_avg.sv
// Sums huil+hart stress over 2^WIN_LOG2 accepted samples and emits the truncated mean.
// Latency: avg/avg_valid register 1 cycle after the window's last sample; no backpressure, clr wins over samples.
module stress_window_avg #(
    parameter int SAMPLE_W = 8,
    parameter int WIN_LOG2 = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] huil_volume,
    input  logic [SAMPLE_W-1:0] hart_ritme,
    output logic [SAMPLE_W:0]   avg,
    output logic                avg_valid
);

    localparam int ACC_W = SAMPLE_W + 1 + WIN_LOG2;

    logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [SAMPLE_W:0]   avg_q, avg_d;
    logic                vld_q, vld_d;
    logic [SAMPLE_W:0]   stress;

    always_comb begin
        stress  = {1'b0, huil_volume} + {1'b0, hart_ritme};
        acc_sum = acc_q + ACC_W'(stress);
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        avg_d   = avg_q;
        vld_d   = 1'b0;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (sample_valid) begin
            if (cnt_q == '1) begin
                // window closes: publish the mean and restart on the same edge
                acc_d = '0;
                cnt_d = '0;
                avg_d = acc_sum[ACC_W-1:WIN_LOG2];
                vld_d = 1'b1;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
            avg_q <= '0;
            vld_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            avg_q <= avg_d;
            vld_q <= vld_d;
        end
    end

    assign avg       = avg_q;
    assign avg_valid = vld_q;

endmodule

// File: rtl/adaptive_rock_ctrl.sv
// Hill-climbing rocking controller: steps A/F one axis at a time toward lower windowed stress, parks at a local minimum.
// Latency: settings change on the APPLY/DECIDE edge; no backpressure. PARK_REARM_EN lets a stress rise restart the search.
module adaptive_rock_ctrl
    import rock_pkg::*;
#(
    parameter int SAMPLE_W   = 8,
    parameter int SET_W      = 4,
    parameter int WIN_LOG2   = 4,
    parameter int SETTLE_WIN = 2,
    parameter int HYST       = 4,
    parameter int START_A    = 4,
    parameter int START_F    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] huilVolume,
    input  logic [SAMPLE_W-1:0] hartRitme,
    output logic [SET_W-1:0]    A,
    output logic [SET_W-1:0]    F,
    output logic [SAMPLE_W:0]   stress_avg,
    output logic                improved,
    output logic                parked
);

    localparam int                  SC_W        = (SETTLE_WIN < 2) ? 1 : $clog2(SETTLE_WIN);
    localparam logic [SC_W-1:0]     SETTLE_LAST = SC_W'((SETTLE_WIN > 0) ? SETTLE_WIN - 1 : 0);
    localparam logic [2:0]          FAIL_LIMIT  = 3'(N_CAND);
    localparam logic [SAMPLE_W+1:0] HYST_X      = (SAMPLE_W + 2)'(HYST);

    state_t              state_q, state_d;
    logic [SET_W-1:0]    a_q, a_d, f_q, f_d;
    logic [SAMPLE_W:0]   base_q, base_d, trial_q, trial_d;
    cand_t               cand_q, cand_d;
    logic [2:0]          fail_q, fail_d, fail_inc;
    logic [SC_W-1:0]     settle_q, settle_d;
    logic                improved_q, improved_d;

    logic [SET_W-1:0]    cur, stepped, reverted;
    logic                at_limit, keep;
    logic                win_clr, avg_valid;
    logic [SAMPLE_W:0]   avg;

    // Samples are only meaningful while a window is being measured
    assign win_clr = !enable || (state_q == S_IDLE) || (state_q == S_APPLY) || (state_q == S_DECIDE);

    stress_window_avg #(
        .SAMPLE_W (SAMPLE_W),
        .WIN_LOG2 (WIN_LOG2)
    ) u_win (
        .clk          (clk),
        .reset        (reset),
        .clr          (win_clr),
        .sample_valid (sample_valid),
        .huil_volume  (huilVolume),
        .hart_ritme   (hartRitme),
        .avg          (avg),
        .avg_valid    (avg_valid)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        f_d        = f_q;
        base_d     = base_q;
        trial_d    = trial_q;
        cand_d     = cand_q;
        fail_d     = fail_q;
        settle_d   = settle_q;
        improved_d = 1'b0;

        cur      = (cand_q.axis == AXIS_A) ? a_q : f_q;
        at_limit = (cand_q.dir == DIR_UP) ? (cur == '1) : (cur == '0);
        stepped  = (cand_q.dir == DIR_UP) ? cur + 1'b1 : cur - 1'b1;
        reverted = (cand_q.dir == DIR_UP) ? cur - 1'b1 : cur + 1'b1;
        fail_inc = fail_q + 1'b1;
        keep     = ({1'b0, trial_q} + HYST_X) <= {1'b0, base_q};

        if (!enable) begin
            state_d = S_IDLE;
            a_d     = '0;
            f_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    a_d     = SET_W'(START_A);
                    f_d     = SET_W'(START_F);
                    state_d = S_BASE;
                end
                S_BASE: if (avg_valid) begin
                    base_d  = avg;
                    cand_d  = CAND_FIRST;
                    fail_d  = '0;
                    state_d = S_APPLY;
                end
                S_APPLY: begin
                    if (at_limit) begin
                        // A step off the range edge counts as a failed trial without measuring
                        fail_d = fail_inc;
                        cand_d = next_cand(cand_q);
                        if (fail_inc == FAIL_LIMIT) state_d = S_PARKED;
                    end else begin
                        if (cand_q.axis == AXIS_A) a_d = stepped;
                        else                       f_d = stepped;
                        settle_d = '0;
                        state_d  = (SETTLE_WIN == 0) ? S_TRIAL : S_SETTLE;
                    end
                end
                S_SETTLE: if (avg_valid) begin
                    if (settle_q == SETTLE_LAST) state_d = S_TRIAL;
                    else                         settle_d = settle_q + 1'b1;
                end
                S_TRIAL: if (avg_valid) begin
                    trial_d = avg;
                    state_d = S_DECIDE;
                end
                S_DECIDE: begin
                    if (keep) begin
                        base_d     = trial_q;
                        improved_d = 1'b1;
                        fail_d     = '0;
                        state_d    = S_APPLY;
                    end else begin
                        if (cand_q.axis == AXIS_A) a_d = reverted;
                        else                       f_d = reverted;
                        fail_d  = fail_inc;
                        cand_d  = next_cand(cand_q);
                        state_d = (fail_inc == FAIL_LIMIT) ? S_PARKED : S_APPLY;
                    end
                end
                S_PARKED: begin
`ifdef PARK_REARM_EN
                    if (avg_valid && ({1'b0, avg} >= ({1'b0, base_q} + HYST_X))) begin
                        base_d  = avg;
                        fail_d  = '0;
                        cand_d  = CAND_FIRST;
                        state_d = S_APPLY;
                    end
`else
                    state_d = S_PARKED;
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            f_q        <= '0;
            base_q     <= '0;
            trial_q    <= '0;
            cand_q     <= CAND_FIRST;
            fail_q     <= '0;
            settle_q   <= '0;
            improved_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            f_q        <= f_d;
            base_q     <= base_d;
            trial_q    <= trial_d;
            cand_q     <= cand_d;
            fail_q     <= fail_d;
            settle_q   <= settle_d;
            improved_q <= improved_d;
        end
    end

    assign A          = a_q;
    assign F          = f_q;
    assign stress_avg = avg;
    assign improved   = improved_q;
    assign parked     = (state_q == S_PARKED);

endmodule

// File: tb/tb_adaptive_rock_ctrl.sv
// Bench for adaptive_rock_ctrl: procedural search model compared every cycle, plus hand-computed literal checks.
module tb_adaptive_rock_ctrl;

    localparam int SW   = 8;
    localparam int SETW = 4;
    localparam int WL   = 2;
    localparam int SWIN = 1;
    localparam int HY   = 4;
    localparam int SA   = 4;
    localparam int SF   = 4;
    localparam int NWIN = 1 << WL;
    localparam int AMAX = (1 << SETW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          sample_valid = 1'b0;
    logic [SW-1:0] huil = '0, hart = '0;
    logic [SETW-1:0] a_o, f_o;
    logic [SW:0]     avg_o;
    logic            imp_o, park_o;

    logic            enable2 = 1'b0;
    logic            valid2 = 1'b1;
    logic [SW-1:0]   huil2 = 8'd50, hart2 = 8'd50;
    logic [SETW-1:0] a2, f2;
    logic [SW:0]     avg2;
    logic            imp2, park2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    adaptive_rock_ctrl #(.WIN_LOG2(WL), .SETTLE_WIN(SWIN)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
        .huilVolume(huil), .hartRitme(hart), .A(a_o), .F(f_o),
        .stress_avg(avg_o), .improved(imp_o), .parked(park_o)
    );

    adaptive_rock_ctrl #(.WIN_LOG2(WL), .SETTLE_WIN(SWIN), .START_A(15)) dut2 (
        .clk(clk), .reset(reset), .enable(enable2), .sample_valid(valid2),
        .huilVolume(huil2), .hartRitme(hart2), .A(a2), .F(f2),
        .stress_avg(avg2), .improved(imp2), .parked(park2)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_A = 0, m_F = 0, m_avg = 0, m_acc = 0, m_cnt = 0;
    bit  m_vld = 0, m_parked = 0, m_improved = 0;
    int  base = 0, trial = 0, cand = 0, fail = 0;

    // One clock edge. listen=0 means the controller is not measuring, so the window is discarded.
    task automatic tick(input bit listen, output bit ab, output bit v, output int av);
        @(posedge clk);
        v = m_vld;
        av = m_avg;
        ab = 0;
        m_improved = 0;
        if (reset || !enable) begin
            if (reset) m_avg = 0;
            m_A = 0; m_F = 0; m_parked = 0;
            m_acc = 0; m_cnt = 0; m_vld = 0;
            ab = 1;
        end else begin
            m_vld = 0;
            if (!listen) begin
                m_acc = 0; m_cnt = 0;
            end else if (sample_valid) begin
                m_acc += int'(huil) + int'(hart);
                m_cnt++;
                if (m_cnt == NWIN) begin
                    m_avg = m_acc / NWIN;
                    m_vld = 1;
                    m_acc = 0; m_cnt = 0;
                end
            end
        end
    endtask

    task automatic wait_window(output bit ab, output int av);
        bit v;
        ab = 0; v = 0; av = 0;
        while (!ab && !v) tick(1, ab, v, av);
    endtask

    task automatic park_wait(output bit ab);
        bit v;
        int av;
        ab = 0;
        forever begin
            tick(1, ab, v, av);
            if (ab) return;
`ifdef PARK_REARM_EN
            if (v && av >= base + HY) begin
                base = av; fail = 0; cand = 0; m_parked = 0;
                return;
            end
`endif
        end
    endtask

    initial begin : model
        bit ab, v;
        int av, nv, step;
        forever begin
            ab = 1;
            while (ab) tick(0, ab, v, av);
            m_A = SA; m_F = SF;
            wait_window(ab, av);
            if (ab) continue;
            base = av; cand = 0; fail = 0;
            while (!ab) begin
                tick(0, ab, v, av);
                if (ab) break;
                step = (cand % 2 == 0) ? 1 : -1;
                nv = ((cand < 2) ? m_A : m_F) + step;
                if (nv < 0 || nv > AMAX) begin
                    fail++; cand = (cand + 1) % 4;
                    if (fail == 4) begin m_parked = 1; park_wait(ab); end
                    continue;
                end
                if (cand < 2) m_A = nv; else m_F = nv;
                for (int s = 0; s < SWIN && !ab; s++) wait_window(ab, av);
                if (ab) break;
                wait_window(ab, trial);
                if (ab) break;
                tick(0, ab, v, av);
                if (ab) break;
                if (trial + HY <= base) begin
                    base = trial; m_improved = 1; fail = 0;
                end else begin
                    if (cand < 2) m_A -= step; else m_F -= step;
                    fail++; cand = (cand + 1) % 4;
                    if (fail == 4) begin m_parked = 1; park_wait(ab); end
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("model A", int'(a_o), m_A);
                check("model F", int'(f_o), m_F);
                check("model stress_avg", int'(avg_o), m_avg);
                check("model parked", int'(park_o), int'(m_parked));
                check("model improved", int'(imp_o), int'(m_improved));
            end
        end
    end

    // ---------------- stimulus ----------------
    int mode = 0;
    int stress_c = 100;
    bit gaps = 0;

    function automatic int land(input int a, input int f);
        if (a == 5 && f == 4) return 80;
        if (a == 6 && f == 4) return 90;
        return 100;
    endfunction

    initial begin : stim
        int cyc, s;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            s = (mode == 1) ? land(int'(a_o), int'(f_o)) : stress_c;
            huil = SW'(s / 2);
            hart = SW'(s - s / 2);
            sample_valid = gaps ? (cyc % 7 != 3) : 1'b1;
        end
    end

    int imp_cnt = 0, a_max = 0;
    bit saw_unpark = 0;

    task automatic cycle();
        @(negedge clk);
        if (imp_o) imp_cnt++;
        if (int'(a_o) > a_max) a_max = int'(a_o);
        if (!park_o) saw_unpark = 1;
    endtask

    task automatic wait_parked(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (park_o) break;
        end
        check(name, int'(park_o), 1);
    endtask

    task automatic wait_a(input string name, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (int'(a_o) == target) break;
        end
        check(name, int'(a_o), target);
    endtask

    initial begin : main
        @(negedge clk);
        check("reset A", int'(a_o), 0);
        check("reset F", int'(f_o), 0);
        check("reset stress_avg", int'(avg_o), 0);
        check("reset parked", int'(park_o), 0);
        check("reset improved", int'(imp_o), 0);
        @(negedge clk);
        reset = 1'b0;
        cycle();

        // START_A at the top of the range: A+ is skipped without a measurement
        enable2 = 1'b1;
        cycle();
        check("dut2 load A", int'(a2), 15);
        repeat (4) cycle();
        check("dut2 first avg", int'(avg2), 100);
        repeat (2) cycle();
        check("dut2 A+ skipped", int'(a2), 15);
        cycle();
        check("dut2 A- applied", int'(a2), 14);
        repeat (3) cycle();
        check("dut2 A- held in settle", int'(a2), 14);
        enable2 = 1'b0;
        cycle();
        check("dut2 disable A", int'(a2), 0);

        // Flat stress: every candidate fails and the search parks at the start point
        mode = 0; stress_c = 100; imp_cnt = 0;
        enable = 1'b1;
        cycle();
        check("load A", int'(a_o), 4);
        repeat (3) cycle();
        check("avg before 4th sample", int'(avg_o), 0);
        cycle();
        check("avg after 4th sample", int'(avg_o), 100);
        wait_parked("flat park", 400);
        check("flat park A", int'(a_o), 4);
        check("flat park F", int'(f_o), 4);
        check("flat no improvement", imp_cnt, 0);

        // Stress rises while parked
        stress_c = 110; saw_unpark = 0; a_max = 0;
        repeat (60) cycle();
`ifdef PARK_REARM_EN
        check("rearm unparked", int'(saw_unpark), 1);
        check("rearm retried A+", a_max, 5);
`else
        check("parked holds", int'(saw_unpark), 0);
        check("parked A holds", a_max, 4);
`endif

        // Stress landscape with a minimum at A=5
        enable = 1'b0;
        cycle();
        check("disable A", int'(a_o), 0);
        check("disable parked", int'(park_o), 0);
        mode = 1; gaps = 1; imp_cnt = 0; a_max = 0;
        enable = 1'b1;
        wait_parked("landscape park", 2000);
        check("landscape A", int'(a_o), 5);
        check("landscape F", int'(f_o), 4);
        check("landscape improved once", imp_cnt, 1);
        check("landscape tried A=6", a_max, 6);
        repeat (12) cycle();
        check("landscape parked avg", int'(avg_o), 80);

        // enable dropped during SETTLE, then a fresh window after re-enable
        mode = 0; gaps = 0; stress_c = 100;
        enable = 1'b0;
        cycle();
        enable = 1'b1;
        wait_a("reach settle", 5, 100);
        repeat (2) cycle();
        enable = 1'b0; stress_c = 60;
        cycle();
        check("settle drop A", int'(a_o), 0);
        check("settle drop F", int'(f_o), 0);
        check("settle drop parked", int'(park_o), 0);
        cycle();
        enable = 1'b1;
        cycle();
        check("re-enable A", int'(a_o), 4);
        repeat (3) cycle();
        check("fresh window pending", int'(avg_o), 100);
        cycle();
        check("fresh window avg", int'(avg_o), 60);

        // Asynchronous reset in the middle of TRIAL
        wait_a("reach settle 2", 5, 100);
        repeat (6) cycle();
        #2 reset = 1'b1;
        #1;
        check("async reset A", int'(a_o), 0);
        check("async reset F", int'(f_o), 0);
        check("async reset stress_avg", int'(avg_o), 0);
        check("async reset parked", int'(park_o), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
